// File: rtl/dataram_copy_arbiter.sv
// Arbitrates the 256x8 data RAM between the CPU port (absolute priority) and a block-copy engine.
// Optional fill mode (constant-value block write) is enabled by defining DATARAM_COPY_FILL_EN.
module dataram_copy_arbiter (
    input  logic       CLK,
    input  logic       Reset,
    input  logic       CpuRead,
    input  logic       CpuWrite,
    input  logic [7:0] CpuAddr,
    input  logic [7:0] CpuDataIn,
    output logic [7:0] CpuDataOut,
    input  logic       Start,
    input  logic [7:0] SrcAddr,
    input  logic [7:0] DstAddr,
    input  logic [7:0] Length,
`ifdef DATARAM_COPY_FILL_EN
    input  logic       FillMode,
    input  logic [7:0] FillValue,
`endif
    output logic       Busy,
    output logic       Done,
    output logic [7:0] RamAddr,
    output logic       RamRead,
    output logic       RamWrite,
    output logic [7:0] RamDataIn,
    input  logic [7:0] RamDataOut
);

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_t;

    state_t     state_q, state_d;
    logic [7:0] src_q, src_d;
    logic [7:0] dst_q, dst_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] hold_q, hold_d;
    logic       fill_q, fill_d;
    logic [7:0] fval_q, fval_d;
    logic       fill_start;
    logic [7:0] fval_start;

    logic       cpu_act;
    logic [7:0] eng_addr;
    logic       eng_rd;
    logic       eng_wr;
    logic [7:0] eng_din;

    assign cpu_act = CpuRead | CpuWrite;

`ifdef DATARAM_COPY_FILL_EN
    assign fill_start = FillMode;
    assign fval_start = FillValue;
`else
    assign fill_start = 1'b0;
    assign fval_start = 8'h00;
`endif

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= S_IDLE;
            src_q   <= 8'h00;
            dst_q   <= 8'h00;
            cnt_q   <= 8'h00;
            hold_q  <= 8'h00;
            fill_q  <= 1'b0;
            fval_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            fill_q  <= fill_d;
            fval_q  <= fval_d;
        end
    end

    // Engine only advances on cycles the CPU leaves the RAM idle.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        fill_d  = fill_q;
        fval_d  = fval_q;
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    if (Length != 8'h00) begin
                        src_d   = SrcAddr;
                        dst_d   = DstAddr;
                        cnt_d   = Length;
                        fill_d  = fill_start;
                        fval_d  = fval_start;
                        state_d = fill_start ? S_WR : S_RD;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_RD: begin
                if (!cpu_act) begin
                    hold_d  = RamDataOut;
                    state_d = S_WR;
                end
            end
            S_WR: begin
                if (!cpu_act) begin
                    src_d = src_q + 8'h01;
                    dst_d = dst_q + 8'h01;
                    cnt_d = cnt_q - 8'h01;
                    if (cnt_q == 8'h01) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = fill_q ? S_WR : S_RD;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        eng_addr = 8'h00;
        eng_rd   = 1'b0;
        eng_wr   = 1'b0;
        eng_din  = 8'h00;
        case (state_q)
            S_RD: begin
                eng_addr = src_q;
                eng_rd   = 1'b1;
            end
            S_WR: begin
                eng_addr = dst_q;
                eng_wr   = 1'b1;
                eng_din  = fill_q ? fval_q : hold_q;
            end
            default: ;
        endcase
    end

    // CPU passes straight through, even during Reset; the engine is silenced while Reset is high.
    always_comb begin
        if (cpu_act) begin
            RamAddr   = CpuAddr;
            RamRead   = CpuRead;
            RamWrite  = CpuWrite;
            RamDataIn = CpuDataIn;
        end else if (Reset) begin
            RamAddr   = 8'h00;
            RamRead   = 1'b0;
            RamWrite  = 1'b0;
            RamDataIn = 8'h00;
        end else begin
            RamAddr   = eng_addr;
            RamRead   = eng_rd;
            RamWrite  = eng_wr;
            RamDataIn = eng_din;
        end
    end

    assign CpuDataOut = CpuRead ? RamDataOut : 8'h00;
    assign Busy       = (state_q == S_RD) || (state_q == S_WR);
    assign Done       = (state_q == S_DONE);

endmodule

// File: tb/tb_dataram_copy_arbiter.sv
// Directed self-checking bench for dataram_copy_arbiter with a behavioural 256x8 RAM.
module tb_dataram_copy_arbiter;

    logic       CLK = 1'b0;
    logic       Reset;
    logic       CpuRead;
    logic       CpuWrite;
    logic [7:0] CpuAddr;
    logic [7:0] CpuDataIn;
    logic [7:0] CpuDataOut;
    logic       Start;
    logic [7:0] SrcAddr;
    logic [7:0] DstAddr;
    logic [7:0] Length;
`ifdef DATARAM_COPY_FILL_EN
    logic       FillMode;
    logic [7:0] FillValue;
`endif
    logic       Busy;
    logic       Done;
    logic [7:0] RamAddr;
    logic       RamRead;
    logic       RamWrite;
    logic [7:0] RamDataIn;
    logic [7:0] RamDataOut;

    logic [7:0] mem [0:255] = '{default: 8'h00};

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (RamWrite) mem[RamAddr] <= RamDataIn;
    end
    assign RamDataOut = RamRead ? mem[RamAddr] : 8'h00;

    dataram_copy_arbiter dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .CpuRead    (CpuRead),
        .CpuWrite   (CpuWrite),
        .CpuAddr    (CpuAddr),
        .CpuDataIn  (CpuDataIn),
        .CpuDataOut (CpuDataOut),
        .Start      (Start),
        .SrcAddr    (SrcAddr),
        .DstAddr    (DstAddr),
        .Length     (Length),
`ifdef DATARAM_COPY_FILL_EN
        .FillMode   (FillMode),
        .FillValue  (FillValue),
`endif
        .Busy       (Busy),
        .Done       (Done),
        .RamAddr    (RamAddr),
        .RamRead    (RamRead),
        .RamWrite   (RamWrite),
        .RamDataIn  (RamDataIn),
        .RamDataOut (RamDataOut)
    );

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic cpu_wr(input logic [7:0] a, input logic [7:0] d);
        CpuWrite  = 1'b1;
        CpuAddr   = a;
        CpuDataIn = d;
        step();
        CpuWrite  = 1'b0;
    endtask

    // Launches a job, then walks cycles E+1.. until Done, recording what it sees.
    task automatic do_copy(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l,
                           input int cpu_from, input int cpu_n,
                           input logic [7:0] cpu_a, input logic [7:0] cpu_exp,
                           input int restart_c,
                           output int busy_n, output int done_c,
                           output int wr_n, output int cpu_bad);
        SrcAddr = s;
        DstAddr = d;
        Length  = l;
        Start   = 1'b1;
        step();
        Start   = 1'b0;
        busy_n  = 0;
        done_c  = -1;
        wr_n    = 0;
        cpu_bad = 0;
        for (int c = 1; c <= 100 && done_c < 0; c++) begin
            CpuRead = (c >= cpu_from) && (c < cpu_from + cpu_n);
            CpuAddr = cpu_a;
            if (c == restart_c) begin
                Start   = 1'b1;
                SrcAddr = 8'h13;
                DstAddr = d + 8'h01;
                Length  = 8'd2;
            end else begin
                Start = 1'b0;
            end
            #1;
            if (CpuRead && CpuDataOut !== cpu_exp) cpu_bad++;
            if (Busy) busy_n++;
            if (RamWrite && !CpuWrite) wr_n++;
            if (Done) done_c = c;
            step();
        end
        CpuRead = 1'b0;
        Start   = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        step();
        step();
        total++;
        if (Busy !== 1'b0 || Done !== 1'b0) begin
            bad++;
            $display("FAIL reset_flags: Busy=%b Done=%b expected 0 0", Busy, Done);
        end
        total++;
        if (RamRead !== 1'b0 || RamWrite !== 1'b0 || RamAddr !== 8'h00 || RamDataIn !== 8'h00) begin
            bad++;
            $display("FAIL reset_ram_pins: rd=%b wr=%b addr=%h din=%h expected all 0",
                     RamRead, RamWrite, RamAddr, RamDataIn);
        end
        CpuRead = 1'b1;
        CpuAddr = 8'h33;
        #1;
        total++;
        if (RamRead !== 1'b1 || RamAddr !== 8'h33) begin
            bad++;
            $display("FAIL reset_cpu_pass: rd=%b addr=%h expected 1 33", RamRead, RamAddr);
        end
        CpuRead = 1'b0;
        Reset   = 1'b0;
        step();
    endtask

    task automatic test_cpu_port();
        cpu_wr(8'h10, 8'hAA);
        cpu_wr(8'h11, 8'hBB);
        cpu_wr(8'h12, 8'hCC);
        cpu_wr(8'h13, 8'hDD);
        cpu_wr(8'h05, 8'h11);
        CpuRead = 1'b1;
        CpuAddr = 8'h12;
        #1;
        total++;
        if (CpuDataOut !== 8'hCC) begin
            bad++;
            $display("FAIL cpu_read: got %h expected cc", CpuDataOut);
        end
        CpuRead   = 1'b1;
        CpuWrite  = 1'b1;
        CpuAddr   = 8'h05;
        CpuDataIn = 8'h22;
        #1;
        total++;
        if (CpuDataOut !== 8'h11 || RamWrite !== 1'b1) begin
            bad++;
            $display("FAIL cpu_rw_same: got %h wr=%b expected 11 1", CpuDataOut, RamWrite);
        end
        step();
        CpuRead  = 1'b0;
        CpuWrite = 1'b0;
        #1;
        total++;
        if (mem[8'h05] !== 8'h22) begin
            bad++;
            $display("FAIL cpu_rw_commit: got %h expected 22", mem[8'h05]);
        end
        total++;
        if (CpuDataOut !== 8'h00) begin
            bad++;
            $display("FAIL cpu_idle_out: got %h expected 00", CpuDataOut);
        end
    endtask

    task automatic test_copy_basic();
        int bn, dc, wn, cb;
        do_copy(8'h10, 8'h80, 8'd4, 0, 0, 8'h00, 8'h00, 0, bn, dc, wn, cb);
        total++;
        if (bn != 8 || dc != 9 || wn != 4) begin
            bad++;
            $display("FAIL copy_timing: busy=%0d done=%0d writes=%0d expected 8 9 4", bn, dc, wn);
        end
        total++;
        if ({mem[8'h80], mem[8'h81], mem[8'h82], mem[8'h83]} !== 32'hAABBCCDD) begin
            bad++;
            $display("FAIL copy_data: got %h%h%h%h expected aabbccdd",
                     mem[8'h80], mem[8'h81], mem[8'h82], mem[8'h83]);
        end
    endtask

    task automatic test_cpu_stall();
        int bn, dc, wn, cb;
        do_copy(8'h10, 8'h90, 8'd4, 3, 3, 8'h10, 8'hAA, 0, bn, dc, wn, cb);
        total++;
        if (cb != 0) begin
            bad++;
            $display("FAIL stall_cpu_data: bad cycles=%0d expected 0", cb);
        end
        total++;
        if (dc != 12 || bn != 11) begin
            bad++;
            $display("FAIL stall_timing: done=%0d busy=%0d expected 12 11", dc, bn);
        end
        total++;
        if ({mem[8'h90], mem[8'h91], mem[8'h92], mem[8'h93]} !== 32'hAABBCCDD) begin
            bad++;
            $display("FAIL stall_data: got %h%h%h%h expected aabbccdd",
                     mem[8'h90], mem[8'h91], mem[8'h92], mem[8'h93]);
        end
    endtask

    task automatic test_wrap();
        int bn, dc, wn, cb;
        cpu_wr(8'hFE, 8'h01);
        cpu_wr(8'hFF, 8'h02);
        cpu_wr(8'h00, 8'h03);
        cpu_wr(8'h01, 8'h04);
        do_copy(8'hFE, 8'h40, 8'd4, 0, 0, 8'h00, 8'h00, 0, bn, dc, wn, cb);
        total++;
        if ({mem[8'h40], mem[8'h41], mem[8'h42], mem[8'h43]} !== 32'h01020304) begin
            bad++;
            $display("FAIL wrap_data: got %h%h%h%h expected 01020304",
                     mem[8'h40], mem[8'h41], mem[8'h42], mem[8'h43]);
        end
        total++;
        if (dc != 9) begin
            bad++;
            $display("FAIL wrap_done: done=%0d expected 9", dc);
        end
    endtask

    task automatic test_len_zero();
        int bn, dc, wn, cb;
        do_copy(8'h10, 8'h60, 8'd0, 0, 0, 8'h00, 8'h00, 0, bn, dc, wn, cb);
        total++;
        if (dc != 1 || bn != 0 || wn != 0) begin
            bad++;
            $display("FAIL len0: done=%0d busy=%0d writes=%0d expected 1 0 0", dc, bn, wn);
        end
        total++;
        if (Busy !== 1'b0 || Done !== 1'b0) begin
            bad++;
            $display("FAIL len0_idle: Busy=%b Done=%b expected 0 0", Busy, Done);
        end
    endtask

    task automatic test_start_ignored();
        int bn, dc, wn, cb;
        do_copy(8'h10, 8'hA0, 8'd4, 0, 0, 8'h00, 8'h00, 3, bn, dc, wn, cb);
        total++;
        if (dc != 9 || wn != 4) begin
            bad++;
            $display("FAIL restart_timing: done=%0d writes=%0d expected 9 4", dc, wn);
        end
        total++;
        if ({mem[8'hA0], mem[8'hA1], mem[8'hA2], mem[8'hA3]} !== 32'hAABBCCDD) begin
            bad++;
            $display("FAIL restart_data: got %h%h%h%h expected aabbccdd",
                     mem[8'hA0], mem[8'hA1], mem[8'hA2], mem[8'hA3]);
        end
    endtask

    task automatic test_reset_midcopy();
        int seen_done;
        SrcAddr = 8'h10;
        DstAddr = 8'hB0;
        Length  = 8'd4;
        Start   = 1'b1;
        step();
        Start = 1'b0;
        for (int c = 1; c < 5; c++) step();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        total++;
        if (Busy !== 1'b0) begin
            bad++;
            $display("FAIL midreset_busy: Busy=%b expected 0", Busy);
        end
        seen_done = 0;
        for (int c = 0; c < 15; c++) begin
            if (Done || Busy) seen_done++;
            step();
        end
        total++;
        if (seen_done != 0) begin
            bad++;
            $display("FAIL midreset_quiet: active cycles=%0d expected 0", seen_done);
        end
        total++;
        if ({mem[8'hB0], mem[8'hB1], mem[8'hB2], mem[8'hB3]} !== 32'hAABB0000) begin
            bad++;
            $display("FAIL midreset_data: got %h%h%h%h expected aabb0000",
                     mem[8'hB0], mem[8'hB1], mem[8'hB2], mem[8'hB3]);
        end
    endtask

`ifdef DATARAM_COPY_FILL_EN
    task automatic test_fill();
        int bn, dc, wn, cb;
        FillMode  = 1'b1;
        FillValue = 8'h5A;
        do_copy(8'h00, 8'h20, 8'd3, 0, 0, 8'h00, 8'h00, 0, bn, dc, wn, cb);
        FillMode = 1'b0;
        total++;
        if (bn != 3 || dc != 4) begin
            bad++;
            $display("FAIL fill_timing: busy=%0d done=%0d expected 3 4", bn, dc);
        end
        total++;
        if ({mem[8'h20], mem[8'h21], mem[8'h22], mem[8'h23]} !== 32'h5A5A5A00) begin
            bad++;
            $display("FAIL fill_data: got %h%h%h%h expected 5a5a5a00",
                     mem[8'h20], mem[8'h21], mem[8'h22], mem[8'h23]);
        end
    endtask
`endif

    initial begin
        Reset     = 1'b1;
        CpuRead   = 1'b0;
        CpuWrite  = 1'b0;
        CpuAddr   = 8'h00;
        CpuDataIn = 8'h00;
        Start     = 1'b0;
        SrcAddr   = 8'h00;
        DstAddr   = 8'h00;
        Length    = 8'h00;
`ifdef DATARAM_COPY_FILL_EN
        FillMode  = 1'b0;
        FillValue = 8'h00;
`endif
        test_reset();
        test_cpu_port();
        test_copy_basic();
        test_cpu_stall();
        test_wrap();
        test_len_zero();
        test_start_ignored();
        test_reset_midcopy();
`ifdef DATARAM_COPY_FILL_EN
        test_fill();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
